mcp3202_spi: RTL and testbench



---
 rtl/mcp3202_spi.sv | 132 +++++++++++++
 tb/tb_mcp3202_spi.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mcp3202_spi.sv
`timescale 1ns/1ps
// mcp3202_spi: SPI master for the MCP3202 12-bit ADC with a one-cycle tvalid output.
// Ports: clk/rst (sync, active-high); miso/mosi/sck/cs to the ADC pins;
//        ready = downstream tready; data = {4'h0, sample}; dv = one-clk tvalid pulse.
// One frame per FCLK/FSMPL clocks. SCK runs at 500 kHz with a 1 us half period.
// data/dv update one half period before cs rises. There is no buffering.
module mcp3202_spi #(
  parameter int FCLK  = 100_000_000,
  parameter int FSMPL = 500,
  parameter bit SGL   = 1'b1,
  parameter bit ODD   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miso,
  input  logic        ready,
  output logic        mosi,
  output logic        sck,
  output logic        cs,
  output logic [15:0] data,
  output logic        dv
);

  localparam int HALF   = FCLK / 1_000_000;
  localparam int PERIOD = FCLK / FSMPL;
  localparam int CW     = $clog2(PERIOD);
  localparam int TW     = $clog2(HALF);

  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_START = CW'(HALF);
  localparam logic [TW-1:0] TMR_LAST  = TW'(HALF - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CS_SETUP = 2'd1;
  localparam logic [1:0] CLOCKING = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [CW-1:0] cnt;
  logic [1:0]    state;
  logic [TW-1:0] tmr;
  logic [4:0]    pulse;
  logic [11:0]   shift;
  logic          tmr_end;
  logic          next_mosi;

  assign tmr_end = (tmr == TMR_LAST);

  // Command bit for the pulse after the one that is ending. It is driven at that
  // pulse's SCK fall. START goes out with the CS fall, so it is not listed here.
  always_comb begin
    next_mosi = 1'b0;
    case (pulse)
      5'd1:    next_mosi = SGL;
      5'd2:    next_mosi = ODD;
      5'd3:    next_mosi = 1'b1;  // MSBF
      default: next_mosi = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      state <= IDLE;
      tmr   <= '0;
      pulse <= '0;
      shift <= '0;
      cs    <= 1'b1;
      sck   <= 1'b0;
      mosi  <= 1'b0;
      data  <= '0;
      dv    <= 1'b0;
    end else begin
      dv  <= 1'b0;
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      tmr <= tmr_end ? '0 : tmr + 1'b1;

      case (state)
        IDLE: begin
          tmr <= '0;
          // The frame start at count HALF keeps CS high for at least 1 us after reset.
          if (cnt == CNT_START) begin
            state <= CS_SETUP;
            cs    <= 1'b0;
            mosi  <= 1'b1;  // START
          end
        end

        CS_SETUP: begin
          if (tmr_end) begin
            state <= CLOCKING;
            sck   <= 1'b1;
            pulse <= 5'd1;
          end
        end

        CLOCKING: begin
          if (tmr_end) begin
            if (sck) begin
              // End of a high half.
              sck  <= 1'b0;
              mosi <= next_mosi;
              if (pulse == 5'd17) begin
                state <= DONE;
                data  <= {4'h0, shift};
                dv    <= ready;  // the sample is dropped unflagged if downstream is not ready
              end
            end else begin
              // End of a low half: rise into pulse+1. MISO is sampled on this
              // rising clk. Pulse 5 carries the null bit, and pulses 6..17
              // carry B11..B0.
              sck   <= 1'b1;
              pulse <= pulse + 1'b1;
              if (pulse >= 5'd5) begin
                shift <= {shift[10:0], miso};
              end
            end
          end
        end

        DONE: begin
          if (tmr_end) begin
            state <= IDLE;
            cs    <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcp3202_spi.sv
`timescale 1ns/1ps
// tb_mcp3202_spi: directed bench for mcp3202_spi. Three instances run at
// 100, 10 and 200 MHz, each with FSMPL=20000 (50 us frame period). Each
// instance has a behavioural MCP3202 and an edge-timestamp monitor.
module tb_mcp3202_spi;

  logic [2:0]  rst;
  logic [2:0]  ready;
  logic [2:0]  run;
  logic [2:0]  cs_all;
  logic [11:0] word [3];

  int          n_chk  = 0;
  int          n_fail = 0;
  realtime     t_rel, t_rel0, f1_fall, f1_rise;
  longint      d;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int  FC = (g == 0) ? 100_000_000 : (g == 1) ? 10_000_000 : 200_000_000;
    localparam real HP = (g == 0) ? 5.0 : (g == 1) ? 50.0 : 2.5;

    logic        clk  = 1'b0;
    logic        miso = 1'b0;
    logic        mosi, sck, cs, dv;
    logic [15:0] data;

    realtime     t_fall = 0, t_csr = 0, t_rise1 = 0, t_rise2 = 0, t_dv = 0;
    int          nrise = 0, ndv = 0;
    logic [3:0]  cmd = '0;

    initial forever begin
      #(HP);
      if (run[g]) clk = ~clk;
    end

    mcp3202_spi #(.FCLK(FC), .FSMPL(20000), .SGL(1'b1), .ODD(1'b0)) dut (
      .clk  (clk),
      .rst  (rst[g]),
      .miso (miso),
      .ready(ready[g]),
      .mosi (mosi),
      .sck  (sck),
      .cs   (cs),
      .data (data),
      .dv   (dv)
    );

    assign cs_all[g] = cs;

    always @(negedge cs) begin
      t_fall = $realtime;
      nrise  = 0;
      ndv    = 0;
    end

    always @(posedge cs) t_csr = $realtime;

    // The ADC latches DIN on each SCK rise.
    always @(posedge sck) begin
      if (nrise == 0) t_rise1 = $realtime;
      if (nrise == 1) t_rise2 = $realtime;
      if (nrise < 4) cmd[3-nrise] = mosi;
      nrise++;
    end

    // The ADC drives DOUT after each SCK fall: the null bit after rise 4, then B11..B0.
    always @(negedge sck) begin
      if (nrise >= 5 && nrise <= 16) miso = word[g][16-nrise];
      else                           miso = 1'b0;
    end

    always @(negedge clk) begin
      if (dv === 1'b1) begin
        ndv++;
        t_dv = $realtime;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_cs(input int g, input logic lvl, input int max_ns, input string tag);
    int w = 0;
    while (cs_all[g] !== lvl && w < max_ns) begin
      #10;
      w += 10;
    end
    chk(tag, 64'(cs_all[g]), 64'(lvl));
  endtask

  task automatic alt_check(input string tag, input int tper, input realtime tfall,
                           input realtime trise1, input realtime trise2, input realtime tcsr,
                           input int nr, input int ndv, input logic [15:0] dat);
    longint dl;
    dl = longint'(tfall - t_rel0);
    chk({tag, "_fall_dly_in_range"}, 64'(dl >= 1000 && dl <= 1000 + tper), 64'd1);
    chk({tag, "_tsucs"},   64'(longint'(trise1 - tfall)), 64'd1000);
    chk({tag, "_sck_per"}, 64'(longint'(trise2 - trise1)), 64'd2000);
    chk({tag, "_cs_low"},  64'(longint'(tcsr - tfall)), 64'd35000);
    chk({tag, "_pulses"},  64'(nr), 64'd17);
    chk({tag, "_dv_cnt"},  64'(ndv), 64'd1);
    chk({tag, "_data"},    64'(dat), 64'h0FFF);
  endtask

  initial begin
    rst     = '1;
    ready   = '1;
    run     = '1;
    word[0] = 12'h75F;
    word[1] = 12'hFFF;
    word[2] = 12'hFFF;

    #101;
    chk("rst_cs",   64'(gi[0].cs),   64'd1);
    chk("rst_sck",  64'(gi[0].sck),  64'd0);
    chk("rst_mosi", 64'(gi[0].mosi), 64'd0);
    chk("rst_dv",   64'(gi[0].dv),   64'd0);
    chk("rst_data", 64'(gi[0].data), 64'd0);

    #100;
    rst    = '0;
    t_rel  = $realtime;
    t_rel0 = t_rel;

    // Frame 1: 0x75F, ready high.
    wait_cs(0, 1'b0, 3000, "f1_cs_fall");
    d = longint'(gi[0].t_fall - t_rel);
    chk("f1_fall_dly_in_range", 64'(d >= 1000 && d <= 1010), 64'd1);
    wait_cs(0, 1'b1, 40000, "f1_cs_rise");
    chk("f1_tsucs",   64'(longint'(gi[0].t_rise1 - gi[0].t_fall)), 64'd1000);
    chk("f1_cmd",     64'(gi[0].cmd), 64'b1101);
    chk("f1_pulses",  64'(gi[0].nrise), 64'd17);
    chk("f1_cs_low",  64'(longint'(gi[0].t_csr - gi[0].t_fall)), 64'd35000);
    chk("f1_sck_per", 64'(longint'(gi[0].t_rise2 - gi[0].t_rise1)), 64'd2000);
    chk("f1_data",    64'(gi[0].data), 64'h075F);
    chk("f1_dv_cnt",  64'(gi[0].ndv), 64'd1);
    // dv is sampled half a clk after its edge. That edge is HALF clks before cs rises.
    chk("f1_dv_lead", 64'(longint'(gi[0].t_csr - gi[0].t_dv)), 64'd995);

    // The 10 MHz and 200 MHz instances must show the same microsecond timing.
    wait_cs(1, 1'b1, 5000, "g1_cs_rise");
    wait_cs(2, 1'b1, 5000, "g2_cs_rise");
    alt_check("f10m", 100, gi[1].t_fall, gi[1].t_rise1, gi[1].t_rise2, gi[1].t_csr,
              gi[1].nrise, gi[1].ndv, gi[1].data);
    alt_check("f200m", 5, gi[2].t_fall, gi[2].t_rise1, gi[2].t_rise2, gi[2].t_csr,
              gi[2].nrise, gi[2].ndv, gi[2].data);
    run[1] = 1'b0;
    run[2] = 1'b0;

    // Frame 2: 0x4E8.
    f1_fall = gi[0].t_fall;
    f1_rise = gi[0].t_csr;
    word[0] = 12'h4E8;
    wait_cs(0, 1'b0, 20000, "f2_cs_fall");
    chk("cs_period", 64'(longint'(gi[0].t_fall - f1_fall)), 64'd50000);
    chk("cs_high",   64'(longint'(gi[0].t_fall - f1_rise)), 64'd15000);
    wait_cs(0, 1'b1, 40000, "f2_cs_rise");
    chk("f2_data",   64'(gi[0].data), 64'h04E8);
    chk("f2_dv_cnt", 64'(gi[0].ndv), 64'd1);

    // Frame 3: 0x7FF with ready low. The data still loads, but dv never fires.
    ready[0] = 1'b0;
    word[0]  = 12'h7FF;
    wait_cs(0, 1'b0, 20000, "f3_cs_fall");
    wait_cs(0, 1'b1, 40000, "f3_cs_rise");
    chk("f3_data",   64'(gi[0].data), 64'h07FF);
    chk("f3_dv_cnt", 64'(gi[0].ndv), 64'd0);
    #5000;
    chk("f3_dv_after", 64'(gi[0].ndv), 64'd0);
    chk("f3_data_hold", 64'(gi[0].data), 64'h07FF);
    ready[0] = 1'b1;

    // Frame 4: reset during pulse 10, then a clean restart with 0x123.
    word[0] = 12'h123;
    wait_cs(0, 1'b0, 20000, "f4_cs_fall");
    begin
      int w = 0;
      while (gi[0].nrise < 10 && w < 40000) begin
        #10;
        w += 10;
      end
    end
    chk("f4_at_pulse10", 64'(gi[0].nrise), 64'd10);
    rst[0] = 1'b1;
    #10;
    chk("abort_cs",   64'(gi[0].cs),   64'd1);
    chk("abort_sck",  64'(gi[0].sck),  64'd0);
    chk("abort_mosi", 64'(gi[0].mosi), 64'd0);
    chk("abort_dv",   64'(gi[0].dv),   64'd0);
    chk("abort_data", 64'(gi[0].data), 64'd0);
    chk("abort_dv_cnt", 64'(gi[0].ndv), 64'd0);
    #90;
    rst[0] = 1'b0;
    t_rel  = $realtime;
    wait_cs(0, 1'b0, 3000, "rs_cs_fall");
    d = longint'(gi[0].t_fall - t_rel);
    chk("rs_fall_dly_in_range", 64'(d >= 1000 && d <= 1010), 64'd1);
    wait_cs(0, 1'b1, 40000, "rs_cs_rise");
    chk("rs_cmd",    64'(gi[0].cmd), 64'b1101);
    chk("rs_pulses", 64'(gi[0].nrise), 64'd17);
    chk("rs_data",   64'(gi[0].data), 64'h0123);
    chk("rs_dv_cnt", 64'(gi[0].ndv), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
